clb_array: RTL
==============

# clb_array

Parametrised configurable logic block: NUM_LE logic elements, each with a LUT_K-input lookup table, an output register with configurable initial/set-reset value, and optional register feedback into the LUT. Configuration is loaded at run time through a serial shift chain clocked by K, with length checking and cascade output, instead of being fixed at elaboration. Instances tile into the fabric with the CFG_DOUT of one block driving the CFG_DIN of the next.

## Interface
- LUT_K, 4, LUT inputs per LE (2..6)
- NUM_LE, 2, logic elements per block (1..8)
- Derived: CFG_LE = 2^LUT_K + 3 bits per LE; TOTAL = NUM_LE*CFG_LE
- K  input  1  clock; all state changes on posedge K
- RST  input  1  asynchronous, active-high reset
- I  input  NUM_LE*LUT_K  LUT inputs; LE i uses I[i*LUT_K +: LUT_K], bit 0 = address LSB
- SR  input  NUM_LE  synchronous set/reset per LE (loads QINIT)
- CE  input  NUM_LE  register clock enable per LE (only with CLB_CE_EN)
- O  output  NUM_LE  LE outputs
- CFG_EN  input  1  shift enable for configuration chain
- CFG_DIN  input  1  serial configuration data
- CFG_DOUT  output  1  chain tail (chain[0]), for cascading
- CFG_DONE  output  1  block configured and running
- CFG_ERR  output  1  last load had wrong length (sticky)

## Operation
- Chain: TOTAL-bit register; each posedge K with CFG_EN=1: chain <= {CFG_DIN, chain[TOTAL-1:1]}. After exactly TOTAL shifts the first bit in sits at chain[0].
- LE i field = chain[i*CFG_LE +: CFG_LE]: bits [2^K-1:0] LUT truth table; [2^K] OSEL (0 = O from LUT, 1 = O from Q); [2^K+1] QINIT; [2^K+2] FBSEL (1 = LUT address MSB taken from own Q instead of I).
- LUT output F_i = LUT[addr], addr = slice of I with MSB replaced by Q_i when FBSEL=1.
- Shift counter counts CFG_EN cycles, saturates at TOTAL+1.
- FSM states: UNCFG, LOAD, RUN.
  - UNCFG: CFG_EN=1 -> LOAD (counter cleared then counting, CFG_ERR cleared).
  - LOAD: while CFG_EN=1 shift. First cycle CFG_EN=0: count==TOTAL -> RUN, all Q_i <= QINIT_i; else -> UNCFG, CFG_ERR <= 1.
  - RUN: CFG_EN=1 -> LOAD (reconfiguration; live config bits shift, outputs gated).
- In RUN, per LE on posedge K: SR_i=1 -> Q_i <= QINIT_i; else if enabled -> Q_i <= F_i. SR has priority over CE.
- O_i = CFG_DONE ? (OSEL ? Q_i : F_i) : 0. CFG_DONE = (state==RUN).
- Q_i held (no update) outside RUN.

## Timing
- Reset (RST=1, async): state UNCFG, chain=0, counter=0, all Q=0; O=0, CFG_DOUT=0, CFG_DONE=0, CFG_ERR=0.
- Combinational path I -> O when OSEL=0 (no latency); registered path one cycle I -> Q -> O.
- CFG_DONE rises at the posedge K where CFG_EN is first sampled 0 after a correct load; Q = QINIT visible same edge.
- CFG_DOUT changes only on shifting edges; a bit shifted in appears at CFG_DOUT after TOTAL shifts.
- CFG_EN asserted in RUN: CFG_DONE and O drop to 0 after that edge; SR/CE ignored until RUN re-entered.
- RST mid-load: configuration discarded, state UNCFG.
- Counter overrun (>TOTAL shifts) is an error, same as underrun.

## Configuration
- CLB_CE_EN defined: CE port present; Q_i updates from F_i only when CE_i=1 (SR_i still wins regardless of CE_i).
- CLB_CE_EN undefined: no CE port; Q_i updates from F_i every RUN cycle unless SR_i=1.

## Test plan
Defaults LUT_K=4, NUM_LE=2 (CFG_LE=19, TOTAL=38).
- Reset: pulse RST asynchronously mid-cycle -> O=2'b00, CFG_DONE=0, CFG_ERR=0, CFG_DOUT=0 immediately.
- Combinational load: LE0 LUT=16'h0116, OSEL=0, FBSEL=0; LE1 all zero; 38 shifts then CFG_EN=0 -> CFG_DONE=1; I[3:0]=4'b0001 -> O[0]=1; I[3:0]=4'b0011 -> O[0]=0.
- Length error: shift 37 bits then drop CFG_EN -> CFG_ERR=1, CFG_DONE=0, O=0; shift 39 bits -> same; correct 38-bit reload clears CFG_ERR.
- Feedback toggle: LE0 LUT=16'h00FF, OSEL=1, FBSEL=1, QINIT=0 -> O[0] = 0,1,0,1 on successive edges after CFG_DONE.
- SR/CE: toggle config above, QINIT=1; SR[0]=1 -> O[0]=1 held every cycle; with CLB_CE_EN, CE[0]=0 and SR[0]=0 -> O[0] frozen; SR[0]=1 with CE[0]=0 -> O[0]=1.
- Cascade/reconfig: two instances chained, 76 shifts -> both CFG_DONE=1; assert CFG_EN in RUN -> CFG_DONE=0 and O=0 next edge.

Source files
------------

// File: rtl/clb_array.sv
// -----------------------------------------------------------------------------
// clb_array: run-time configurable logic block.
//
// The block holds NUM_LE logic elements. Each element has a LUT_K-input
// lookup table, an output register with a configurable init/set-reset value
// (QINIT), and optional feedback of its own register into the LUT address MSB.
// Configuration is loaded serially through a TOTAL-bit shift chain. A length
// check gates entry into RUN. CFG_DOUT lets blocks be cascaded into a fabric.
//
// Per-LE configuration field (CFG_LE = 2^LUT_K + 3 bits, LE i at i*CFG_LE):
//   [2^K-1:0] LUT truth table   [2^K] OSEL   [2^K+1] QINIT   [2^K+2] FBSEL
//
// Ports:
//   K         clock, all state changes on posedge
//   RST       asynchronous active-high reset
//   I         LUT inputs, LE i uses I[i*LUT_K +: LUT_K]
//   SR        per-LE synchronous set/reset to QINIT (has priority over CE)
//   CE        per-LE register enable (present only with CLB_CE_EN)
//   O         per-LE outputs, forced to 0 while not configured
//   CFG_EN    configuration shift enable
//   CFG_DIN   serial configuration input
//   CFG_DOUT  chain tail, feeds CFG_DIN of the next block
//   CFG_DONE  block configured and running
//   CFG_ERR   sticky flag: last load had the wrong length
//
// Build option: define CLB_CE_EN to add the CE port and per-LE clock enable.
// -----------------------------------------------------------------------------
module clb_array #(
  parameter int LUT_K  = 4,
  parameter int NUM_LE = 2
) (
  input  logic                      K,
  input  logic                      RST,
  input  logic [NUM_LE*LUT_K-1:0]   I,
  input  logic [NUM_LE-1:0]         SR,
`ifdef CLB_CE_EN
  input  logic [NUM_LE-1:0]         CE,
`endif
  output logic [NUM_LE-1:0]         O,
  input  logic                      CFG_EN,
  input  logic                      CFG_DIN,
  output logic                      CFG_DOUT,
  output logic                      CFG_DONE,
  output logic                      CFG_ERR
);

  localparam int LUT_SIZE = 1 << LUT_K;
  localparam int CFG_LE   = LUT_SIZE + 3;
  localparam int TOTAL    = NUM_LE * CFG_LE;
  // The counter must reach TOTAL+1 so that an overrun stays distinguishable.
  localparam int CNT_W    = $clog2(TOTAL + 2);

  localparam logic [CNT_W-1:0] CNT_TOTAL = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(TOTAL + 1);

  typedef enum logic [1:0] {
    ST_UNCFG,
    ST_LOAD,
    ST_RUN
  } state_e;

  state_e              state_q, state_d;
  logic [TOTAL-1:0]    chain_q, chain_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic                err_q,   err_d;
  logic [NUM_LE-1:0]   q_q,     q_d;

  logic                cfg_done;
  logic [NUM_LE-1:0]   f;
  logic [NUM_LE-1:0]   osel;
  logic [NUM_LE-1:0]   qinit;
  logic [NUM_LE-1:0]   fbsel;
  logic [NUM_LE-1:0]   ce_en;

`ifdef CLB_CE_EN
  assign ce_en = CE;
`else
  assign ce_en = '1;
`endif

  // ---------------------------------------------------------------------------
  // Per-LE decode, LUT and output mux
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_LE; g++) begin : g_le
    logic [CFG_LE-1:0]   field;
    logic [LUT_SIZE-1:0] lut;
    logic [LUT_K-1:0]    addr;

    assign field    = chain_q[g*CFG_LE +: CFG_LE];
    assign lut      = field[LUT_SIZE-1:0];
    assign osel[g]  = field[LUT_SIZE];
    assign qinit[g] = field[LUT_SIZE+1];
    assign fbsel[g] = field[LUT_SIZE+2];

    // Feedback replaces only the address MSB, so a K-input LUT becomes a
    // (K-1)-input function of I plus its own state.
    always_comb begin
      addr = I[g*LUT_K +: LUT_K];
      if (fbsel[g]) addr[LUT_K-1] = q_q[g];
    end

    assign f[g] = lut[addr];
    assign O[g] = cfg_done ? (osel[g] ? q_q[g] : f[g]) : 1'b0;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge K or posedge RST) begin
    if (RST) state_q <= ST_UNCFG;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_UNCFG: if (CFG_EN) state_d = ST_LOAD;
      ST_LOAD:  if (!CFG_EN) state_d = (cnt_q == CNT_TOTAL) ? ST_RUN : ST_UNCFG;
      ST_RUN:   if (CFG_EN) state_d = ST_LOAD;
      default:  state_d = ST_UNCFG;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    cfg_done = (state_q == ST_RUN);
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state: chain, counter, error flag, LE registers
  // ---------------------------------------------------------------------------
  always_comb begin
    chain_d = chain_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    q_d     = q_q;

    if (CFG_EN) chain_d = {CFG_DIN, chain_q[TOTAL-1:1]};

    unique case (state_q)
      ST_LOAD: begin
        if (CFG_EN) begin
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
        end else if (cnt_q == CNT_TOTAL) begin
          q_d = qinit;
        end else begin
          err_d = 1'b1;
        end
      end
      ST_UNCFG, ST_RUN: begin
        if (CFG_EN) begin
          // Entering LOAD: this edge is already the first shift.
          cnt_d = CNT_W'(1);
          err_d = 1'b0;
        end else if (state_q == ST_RUN) begin
          for (int i = 0; i < NUM_LE; i++) begin
            if (SR[i])         q_d[i] = qinit[i];
            else if (ce_en[i]) q_d[i] = f[i];
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: the configuration chain is reset like any other register so that a
  // freshly reset block never drives stale configuration out of CFG_DOUT.
  always_ff @(posedge K or posedge RST) begin
    if (RST) begin
      chain_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      q_q     <= '0;
    end else begin
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      q_q     <= q_d;
    end
  end

  assign CFG_DOUT = chain_q[0];
  assign CFG_DONE = cfg_done;
  assign CFG_ERR  = err_q;

endmodule
